// File: rtl/rtc_display_pkg.sv
// Shared constants for the RTC display shadow: byte map, FSM states and a BCD helper.
package rtc_display_pkg;

  localparam int unsigned ADDR_HOUR0  = 0;
  localparam int unsigned ADDR_HOUR1  = 1;
  localparam int unsigned ADDR_HOUR2  = 2;
  localparam int unsigned ADDR_FECHA0 = 3;
  localparam int unsigned ADDR_FECHA1 = 4;
  localparam int unsigned ADDR_FECHA2 = 5;
  localparam int unsigned ADDR_TIMER0 = 6;
  localparam int unsigned ADDR_TIMER1 = 7;
  localparam int unsigned ADDR_TIMER2 = 8;
  localparam int unsigned ADDR_CTRL   = 9;

  localparam int unsigned NUM_BYTES         = 9;
  localparam int unsigned CTRL_ALARM_EN_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_display_shadow_frame_edge_detect.sv
// Registers vsync once and pulses o_frame_start for one cycle when vsync turns active.
module frame_edge_detect #(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_frame_start
);

  logic r_vsync;
  logic w_active_now;
  logic w_active_prev;

  // Reset to the inactive level so a held-active vsync still yields one pulse after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_vsync <= VSYNC_ACTIVE_LOW;
    else       r_vsync <= i_vsync;
  end

  assign w_active_now  = VSYNC_ACTIVE_LOW ? ~i_vsync : i_vsync;
  assign w_active_prev = VSYNC_ACTIVE_LOW ? ~r_vsync : r_vsync;
  assign o_frame_start = w_active_now && !w_active_prev;

endmodule

// File: rtl/rtc_display_shadow.sv
// Shadow bank for RTC time/date/timer bytes, committed to display registers on vsync start.
// Optional BCD_CHECK_EN: byte writes with a non-BCD nibble are accepted but dropped, setting err.
module rtc_display_shadow #(
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned ADDR_W           = 4,
  parameter int unsigned NUM_BYTES        = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              vsync,
  output logic [7:0]        hour_out1,
  output logic [7:0]        hour_out2,
  output logic [7:0]        hour_out3,
  output logic [7:0]        fecha_out1,
  output logic [7:0]        fecha_out2,
  output logic [7:0]        fecha_out3,
  output logic [7:0]        timer_out1,
  output logic [7:0]        timer_out2,
  output logic [7:0]        timer_out3,
  output logic              activar_alarma,
  output logic              err,
  output logic              busy
);

  import rtc_display_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_shadow [NUM_BYTES];
  logic [7:0]       r_disp   [NUM_BYTES];
  logic [IDX_W-1:0] r_idx;
  logic             r_dirty;
  logic             r_alarm_en;
  logic             r_alarm;
  logic             r_err;

  logic        w_frame_start;
  logic [31:0] w_addr_ext;
  logic        w_bcd_bad;
  logic        w_ready;
  logic        w_busy;
  logic        w_fire;
  logic        w_byte_wr;
  logic        w_ctrl_wr;
  logic        w_set_err;
  logic        w_start_copy;
  logic        w_copy_en;
  logic        w_in_done;
  logic        w_timer_zero;

  frame_edge_detect #(
    .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW)
  ) u_frame_edge (
    .i_clk         (clk),
    .i_rst         (reset),
    .i_vsync       (vsync),
    .o_frame_start (w_frame_start)
  );

  assign w_addr_ext = 32'(wr_addr);

`ifdef BCD_CHECK_EN
  assign w_bcd_bad = !is_bcd(wr_data);
`else
  assign w_bcd_bad = 1'b0;
`endif

  assign w_fire    = wr_valid && w_ready;
  assign w_ctrl_wr = w_fire && (w_addr_ext == ADDR_CTRL);
  assign w_byte_wr = w_fire && (w_addr_ext < NUM_BYTES) && !w_bcd_bad;
  assign w_set_err = w_fire && ((w_addr_ext > ADDR_CTRL) ||
                                ((w_addr_ext < NUM_BYTES) && w_bcd_bad));

  assign w_timer_zero = (r_disp[ADDR_TIMER0] == 8'h00) &&
                        (r_disp[ADDR_TIMER1] == 8'h00) &&
                        (r_disp[ADDR_TIMER2] == 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b1;
    w_busy       = 1'b0;
    w_start_copy = 1'b0;
    w_copy_en    = 1'b0;
    w_in_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_frame_start && r_dirty) begin
          w_state_nxt  = COPY;
          w_start_copy = 1'b1;
        end
      end
      COPY: begin
        w_ready   = 1'b0;
        w_busy    = 1'b1;
        w_copy_en = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = DONE;
      end
      DONE: begin
        w_in_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_dirty    <= 1'b0;
      r_alarm_en <= 1'b0;
      r_alarm    <= 1'b0;
      r_err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        r_shadow[i] <= '0;
        r_disp[i]   <= '0;
      end
    end else begin
      if (w_start_copy)   r_idx <= '0;
      else if (w_copy_en) r_idx <= r_idx + IDX_W'(1);

      // A write landing in the commit-start cycle keeps dirty so it is shown again next frame.
      if (w_byte_wr)         r_dirty <= 1'b1;
      else if (w_start_copy) r_dirty <= 1'b0;

      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (w_byte_wr && (w_addr_ext == i))     r_shadow[i] <= wr_data;
        if (w_copy_en && (32'(r_idx) == i))     r_disp[i]   <= r_shadow[i];
      end

      if (w_ctrl_wr) r_alarm_en <= wr_data[CTRL_ALARM_EN_BIT];

      if (w_ctrl_wr && !wr_data[CTRL_ALARM_EN_BIT]) begin
        r_alarm <= 1'b0;
      end else if (w_in_done) begin
        if (r_alarm_en && w_timer_zero) r_alarm <= 1'b1;
        else if (!w_timer_zero)         r_alarm <= 1'b0;
      end

      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign wr_ready       = w_ready;
  assign busy           = w_busy;
  assign hour_out1      = r_disp[ADDR_HOUR0];
  assign hour_out2      = r_disp[ADDR_HOUR1];
  assign hour_out3      = r_disp[ADDR_HOUR2];
  assign fecha_out1     = r_disp[ADDR_FECHA0];
  assign fecha_out2     = r_disp[ADDR_FECHA1];
  assign fecha_out3     = r_disp[ADDR_FECHA2];
  assign timer_out1     = r_disp[ADDR_TIMER0];
  assign timer_out2     = r_disp[ADDR_TIMER1];
  assign timer_out3     = r_disp[ADDR_TIMER2];
  assign activar_alarma = r_alarm;
  assign err            = r_err;

endmodule

// File: tb/tb_rtc_display_shadow.sv
// Scoreboard bench for rtc_display_shadow: a byte-map model predicts each frame's committed state.
module tb_rtc_display_shadow;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       vsync;
  logic [7:0] hour_out1, hour_out2, hour_out3;
  logic [7:0] fecha_out1, fecha_out2, fecha_out3;
  logic [7:0] timer_out1, timer_out2, timer_out3;
  logic       activar_alarma;
  logic       err;
  logic       busy;

  always #5 clk = ~clk;

  rtc_display_shadow #(
    .VSYNC_ACTIVE_LOW(1'b1),
    .ADDR_W(4),
    .NUM_BYTES(9)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .vsync(vsync),
    .hour_out1(hour_out1), .hour_out2(hour_out2), .hour_out3(hour_out3),
    .fecha_out1(fecha_out1), .fecha_out2(fecha_out2), .fecha_out3(fecha_out3),
    .timer_out1(timer_out1), .timer_out2(timer_out2), .timer_out3(timer_out3),
    .activar_alarma(activar_alarma), .err(err), .busy(busy)
  );

  typedef struct packed {
    logic [71:0] b;
    logic        alarm;
    logic        err;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  snap_t sb_q[$];

  logic [7:0] m_shadow [9];
  logic [7:0] m_disp   [9];
  logic       m_alarm_en, m_alarm, m_dirty, m_err;

  function automatic snap_t observe();
    snap_t s;
    s.b = {timer_out3, timer_out2, timer_out1, fecha_out3, fecha_out2, fecha_out1,
           hour_out3, hour_out2, hour_out1};
    s.alarm = activar_alarma;
    s.err   = err;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    for (int i = 0; i < 9; i++) s.b[8*i +: 8] = m_disp[i];
    s.alarm = m_alarm;
    s.err   = m_err;
    return s;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = 8'h00;
      m_disp[i]   = 8'h00;
    end
    m_alarm_en = 1'b0;
    m_alarm    = 1'b0;
    m_dirty    = 1'b0;
    m_err      = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic write_byte(input logic [3:0] a, input logic [7:0] d, output int stall);
    logic bad;
    stall    = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      stall++;
      if (stall >= 40) begin
        errors++;
        $display("FAIL write_timeout addr %0d stalled %0d cycles, required acceptance", a, stall);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    bad = 1'b0;
`ifdef BCD_CHECK_EN
    bad = (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
`endif
    if (a < 4'd9) begin
      if (bad) m_err = 1'b1;
      else begin
        m_shadow[a] = d;
        m_dirty     = 1'b1;
      end
    end else if (a == 4'd9) begin
      m_alarm_en = d[0];
      if (!d[0]) m_alarm = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic frame_pulse(output int exp_busy);
    logic tz;
    vsync    = 1'b0;
    exp_busy = 0;
    if (m_dirty) begin
      m_disp   = m_shadow;
      m_dirty  = 1'b0;
      exp_busy = 9;
      tz = (m_disp[6] == 8'h00) && (m_disp[7] == 8'h00) && (m_disp[8] == 8'h00);
      if (m_alarm_en && tz) m_alarm = 1'b1;
      else if (!tz)         m_alarm = 1'b0;
    end
    sb_q.push_back(model_snap());
  endtask

  task automatic collect(output snap_t got, output int bcyc, output logic [12:0] atrace);
    bcyc = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (busy) bcyc++;
      atrace[k] = activar_alarma;
    end
    vsync = 1'b1;
    @(posedge clk); #1;
    got = observe();
  endtask

  task automatic test_reset();
    snap_t zero;
    zero = '0;
    #1;
    checks++;
    if (observe() !== zero) begin
      errors++; $display("FAIL reset_async_outputs got %h exp %h", observe(), zero);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (observe() !== zero) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", observe(), zero);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_hour_commit();
    int st, eb, bc;
    snap_t got, exp;
    logic [12:0] at;
    write_byte(4'd0, 8'h12, st);
    write_byte(4'd1, 8'h34, st);
    write_byte(4'd2, 8'h56, st);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (observe() !== model_snap()) begin
      errors++; $display("FAIL hour_no_vsync got %h exp %h", observe(), model_snap());
    end
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL hour_commit got %h exp %h", got, exp);
    end
    checks++;
    if (bc !== eb) begin
      errors++; $display("FAIL hour_busy_cycles got %0d exp %0d", bc, eb);
    end
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (bc !== eb)) begin
      errors++; $display("FAIL clean_frame got %h/%0d exp %h/%0d", got, bc, exp, eb);
    end
  endtask

  task automatic test_stall();
    int st, eb, bc;
    snap_t got, exp;
    logic [12:0] at;
    frame_pulse(eb);
    checks++;
    if (eb !== 0) begin
      errors++; $display("FAIL stall_precond dirty busy %0d exp 0", eb);
    end
    void'(sb_q.pop_front());
    m_shadow[5] = 8'h24;
    m_dirty     = 1'b1;
    vsync = 1'b1;
    @(posedge clk); #1;
    write_byte(4'd5, 8'h24, st);
    frame_pulse(eb);
    @(posedge clk); #1;
    write_byte(4'd3, 8'h07, st);
    checks++;
    if (st !== 9) begin
      errors++; $display("FAIL stall_cycles got %0d exp 9", st);
    end
    exp = sb_q.pop_front();
    got = observe();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL stall_old_frame got %h exp %h", got, exp);
    end
    vsync = 1'b1;
    @(posedge clk); #1;
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (fecha_out1 !== 8'h07)) begin
      errors++; $display("FAIL stall_next_frame got %h exp %h", got, exp);
    end
  endtask

  task automatic test_alarm();
    int st, eb, bc;
    snap_t got, exp;
    logic [12:0] at;
    write_byte(4'd9, 8'h01, st);
    write_byte(4'd6, 8'h00, st);
    write_byte(4'd7, 8'h00, st);
    write_byte(4'd8, 8'h00, st);
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (exp.alarm !== 1'b1)) begin
      errors++; $display("FAIL alarm_set got %h exp %h", got, exp);
    end
    checks++;
    if ((at[10] !== 1'b0) || (at[11] !== 1'b1)) begin
      errors++; $display("FAIL alarm_timing trace %b exp bit10=0 bit11=1", at);
    end
    write_byte(4'd8, 8'h01, st);
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (activar_alarma !== 1'b0)) begin
      errors++; $display("FAIL alarm_clear_nonzero got %h exp %h", got, exp);
    end
    write_byte(4'd8, 8'h00, st);
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (activar_alarma !== 1'b1)) begin
      errors++; $display("FAIL alarm_reset_again got %h exp %h", got, exp);
    end
    write_byte(4'd9, 8'h00, st);
    checks++;
    if (activar_alarma !== 1'b0) begin
      errors++; $display("FAIL alarm_disable_write got %b exp 0", activar_alarma);
    end
  endtask

  task automatic test_errors();
    int st, eb, bc;
    snap_t got, exp;
    logic [12:0] at;
    write_byte(4'd12, 8'h55, st);
    checks++;
    if ((err !== 1'b1) || (observe() !== model_snap())) begin
      errors++; $display("FAIL bad_addr got %h exp %h", observe(), model_snap());
    end
    write_byte(4'd0, 8'h1A, st);
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (bc !== eb)) begin
      errors++; $display("FAIL bcd_write got %h/%0d exp %h/%0d", got, bc, exp, eb);
    end
`ifdef BCD_CHECK_EN
    checks++;
    if (hour_out1 !== 8'h12) begin
      errors++; $display("FAIL bcd_drop hour_out1 got %h exp 12", hour_out1);
    end
`else
    checks++;
    if (hour_out1 !== 8'h1A) begin
      errors++; $display("FAIL bcd_store hour_out1 got %h exp 1a", hour_out1);
    end
`endif
  endtask

  task automatic test_reset_mid_copy();
    int st, eb, bc;
    snap_t got, exp, zero;
    logic [12:0] at;
    zero = '0;
    write_byte(4'd4, 8'h99, st);
    vsync = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (observe() !== zero) begin
      errors++; $display("FAIL reset_mid_copy got %h exp %h", observe(), zero);
    end
    checks++;
    if ((wr_ready !== 1'b1) || (busy !== 1'b0)) begin
      errors++; $display("FAIL reset_mid_copy_ctl ready %b busy %b exp 1 0", wr_ready, busy);
    end
    reset_model();
    vsync = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    frame_pulse(eb);
    collect(got, bc, at);
    exp = sb_q.pop_front();
    checks++;
    if ((got !== exp) || (bc !== 0)) begin
      errors++; $display("FAIL post_reset_frame got %h/%0d exp %h/0", got, bc, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    vsync    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    reset_model();
    test_reset();
    test_hour_commit();
    test_stall();
    test_alarm();
    test_errors();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, required completion");
    $fatal(1);
  end

endmodule
